// File: rtl/adpll_tx_ser.sv
// Serial modulation-bit transmitter for the ADPLL TX path, LSB first.
// Define TX_PREAMBLE_EN to prepend the PREAMBLE byte at the start of each burst.
module adpll_tx_ser #(
    parameter int          BIT_PERIOD = 32,
    parameter logic [7:0]  PREAMBLE   = 8'hAA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] adpll_mode,
    input  logic       channel_lock,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       data_mod,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_abort
);

`ifdef TX_PREAMBLE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, PRE = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
    logic unused_preamble;
    assign unused_preamble = ^PREAMBLE;
`endif

    localparam logic [7:0] LAST = 8'(BIT_PERIOD - 1);

    state_t     state_q, state_n;
    logic [7:0] buf_q, buf_n;
    logic       full_q, full_n;
    logic [7:0] sh_q, sh_n;
    logic [7:0] tmr_q, tmr_n;
    logic [2:0] idx_q, idx_n;
    logic       mod_q, mod_n;
    logic       done_q, done_n;
    logic       abort_q, abort_n;
    logic       go;
    logic       bit_end;
    logic [2:0] idx_nx;

    assign go      = en && channel_lock && (adpll_mode == 2'd3);
    assign bit_end = (tmr_q == LAST);
    assign idx_nx  = idx_q + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            full_q  <= 1'b0;
            sh_q    <= '0;
            tmr_q   <= '0;
            idx_q   <= '0;
            mod_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_n;
            buf_q   <= buf_n;
            full_q  <= full_n;
            sh_q    <= sh_n;
            tmr_q   <= tmr_n;
            idx_q   <= idx_n;
            mod_q   <= mod_n;
            done_q  <= done_n;
            abort_q <= abort_n;
        end
    end

    always_comb begin
        state_n = state_q;
        buf_n   = buf_q;
        full_n  = full_q;
        sh_n    = sh_q;
        tmr_n   = tmr_q;
        idx_n   = idx_q;
        mod_n   = mod_q;
        done_n  = 1'b0;
        abort_n = 1'b0;

        if (data_valid && !full_q) begin
            buf_n  = data_in;
            full_n = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (full_q && go) begin
                    tmr_n = '0;
                    idx_n = '0;
`ifdef TX_PREAMBLE_EN
                    state_n = PRE;
                    sh_n    = PREAMBLE;
                    mod_n   = PREAMBLE[0];
`else
                    state_n = SEND;
                    sh_n    = buf_q;
                    mod_n   = buf_q[0];
                    full_n  = 1'b0;
`endif
                end
            end
`ifdef TX_PREAMBLE_EN
            PRE: begin
                if (bit_end) begin
                    tmr_n = '0;
                    if (idx_q == 3'd7) begin
                        // buffer was held full through the preamble
                        state_n = SEND;
                        sh_n    = buf_q;
                        mod_n   = buf_q[0];
                        full_n  = 1'b0;
                        idx_n   = '0;
                    end else begin
                        mod_n = sh_q[idx_nx];
                        idx_n = idx_nx;
                    end
                end else begin
                    tmr_n = tmr_q + 8'd1;
                end
            end
`endif
            SEND: begin
                if (bit_end) begin
                    tmr_n = '0;
                    if (idx_q != 3'd7) begin
                        mod_n = sh_q[idx_nx];
                        idx_n = idx_nx;
                    end else if (full_q) begin
                        sh_n   = buf_q;
                        mod_n  = buf_q[0];
                        full_n = 1'b0;
                        idx_n  = '0;
                    end else begin
                        state_n = IDLE;
                        mod_n   = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    tmr_n = tmr_q + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // losing go mid-burst overrides everything, including end of bit 7
        if (state_q != IDLE && !go) begin
            state_n = IDLE;
            mod_n   = 1'b0;
            full_n  = 1'b0;
            tmr_n   = '0;
            idx_n   = '0;
            done_n  = 1'b0;
            abort_n = 1'b1;
        end
    end

    assign data_ready = !full_q;
    assign data_mod   = mod_q;
    assign tx_busy    = (state_q != IDLE);
    assign tx_done    = done_q;
    assign tx_abort   = abort_q;

endmodule

// File: tb/tb_adpll_tx_ser.sv
// Self-checking bench for adpll_tx_ser: vector table, random bursts
// against a bit-stream model, and hand-written abort/reset sequences.
module tb_adpll_tx_ser;

    localparam int         BP    = 32;
    localparam logic [7:0] PRE_B = 8'hAA;
`ifdef TX_PREAMBLE_EN
    localparam int         PRE_CYC = 8 * BP;
`else
    localparam int         PRE_CYC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] adpll_mode;
    logic       channel_lock;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       data_mod;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_abort;

    int checks   = 0;
    int failures = 0;

    logic [7:0] feed_q[$];
    bit         exp_q[$];
    bit         rec_q[$];

    typedef struct {
        string       name;
        int          n;
        logic [7:0]  b0, b1, b2;
        logic [23:0] exp_seq;
        int          exp_len;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    adpll_tx_ser #(.BIT_PERIOD(BP), .PREAMBLE(PRE_B)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .adpll_mode(adpll_mode),
        .channel_lock(channel_lock),
        .data_in(data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .data_mod(data_mod),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_abort(tx_abort)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic offer(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int  w  = 0;
        bit  ok = 0;
        while (w < 100) begin
            tick(1);
            w++;
            if (tx_busy) begin
                ok = 1;
                break;
            end
        end
        chk({tag, "_start"}, 32'(ok), 1);
    endtask

    task automatic push_pre();
        exp_q.delete();
`ifdef TX_PREAMBLE_EN
        for (int j = 0; j < 8; j++) exp_q.push_back(PRE_B[j]);
`endif
    endtask

    // reference: each transmitted bit occupies BP consecutive cycles
    task automatic run_burst(input string tag);
        int nb   = feed_q.size();
        int dib  = 0;
        int mism = 0;
        int first = -1;
        fork
            begin
                for (int i = 0; i < nb; i++) begin
                    int w = 0;
                    while (!data_ready && w < 4000) begin
                        tick(1);
                        w++;
                    end
                    chk({tag, "_ready"}, 32'(data_ready), 1);
                    offer(feed_q[i]);
                end
            end
            begin
                int w = 0;
                rec_q.delete();
                wait_busy(tag);
                while (tx_busy && w < 5000) begin
                    rec_q.push_back(data_mod);
                    if (tx_done) dib++;
                    tick(1);
                    w++;
                end
                chk({tag, "_done"}, 32'(tx_done), 1);
                chk({tag, "_mod_after"}, 32'(data_mod), 0);
                chk({tag, "_early_done"}, 32'(dib), 0);
            end
        join
        chk({tag, "_len"}, 32'(rec_q.size()), 32'(exp_q.size() * BP));
        foreach (rec_q[k]) begin
            bit e = (k / BP < exp_q.size()) ? exp_q[k / BP] : 1'b0;
            if (rec_q[k] != e) begin
                mism++;
                if (first < 0) first = k;
            end
        end
        if (mism != 0) $display("  first bad cycle %0d", first);
        chk({tag, "_bits"}, 32'(mism), 0);
        tick(1);
        chk({tag, "_done_pulse"}, 32'(tx_done), 0);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{"a5",     1, 8'hA5, 8'h00, 8'h00, 24'h0000A5, 256};
        vecs[1] = '{"0f_f0",  2, 8'h0F, 8'hF0, 8'h00, 24'h00F00F, 512};
        vecs[2] = '{"triple", 3, 8'h00, 8'hFF, 8'h81, 24'h81FF00, 768};
        vecs[3] = '{"3c",     1, 8'h3C, 8'h00, 8'h00, 24'h00003C, 256};

        rst          = 1'b1;
        en           = 1'b1;
        adpll_mode   = 2'd3;
        channel_lock = 1'b1;
        data_in      = 8'h00;
        data_valid   = 1'b0;
        tick(3);
        chk("rst_ready", 32'(data_ready), 1);
        chk("rst_mod", 32'(data_mod), 0);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_abort", 32'(tx_abort), 0);
        rst = 1'b0;
        tick(2);

        foreach (vecs[i]) begin
            feed_q.delete();
            feed_q.push_back(vecs[i].b0);
            if (vecs[i].n > 1) feed_q.push_back(vecs[i].b1);
            if (vecs[i].n > 2) feed_q.push_back(vecs[i].b2);
            push_pre();
            for (int k = 0; k < 8 * vecs[i].n; k++)
                exp_q.push_back(vecs[i].exp_seq[k]);
            chk({vecs[i].name, "_tbl_len"}, 32'(exp_q.size() * BP),
                32'(vecs[i].exp_len + PRE_CYC));
            run_burst(vecs[i].name);
        end

        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 3);
            feed_q.delete();
            push_pre();
            for (int i = 0; i < n; i++) begin
                logic [7:0] b = 8'($urandom);
                feed_q.push_back(b);
                for (int j = 0; j < 8; j++) exp_q.push_back(b[j]);
            end
            tick($urandom_range(0, 5));
            run_burst("rnd");
        end

        // mode gating: byte held while mode is RX
        adpll_mode = 2'd2;
        offer(8'h3C);
        tick(20);
        chk("gate_ready", 32'(data_ready), 0);
        chk("gate_mod", 32'(data_mod), 0);
        chk("gate_busy", 32'(tx_busy), 0);
        adpll_mode = 2'd3;
        tick(1);
        chk("gate_start", 32'(tx_busy), 1);
        cnt = 0;
        for (int w = 0; w < 1000; w++) begin
            if (tx_done) begin
                cnt = 1;
                break;
            end
            tick(1);
        end
        chk("gate_done", 32'(cnt), 1);
        tick(2);

        // lock loss at bit 3 with next byte buffered
        offer(8'hFF);
        wait_busy("lock");
        tick(PRE_CYC + 3 * BP + 5);
        chk("lock_ready_pre", 32'(data_ready), 1);
        offer(8'h55);
        chk("lock_buffered", 32'(data_ready), 0);
        channel_lock = 1'b0;
        tick(1);
        chk("lock_mod", 32'(data_mod), 0);
        chk("lock_abort", 32'(tx_abort), 1);
        chk("lock_ready", 32'(data_ready), 1);
        chk("lock_busy", 32'(tx_busy), 0);
        chk("lock_nodone", 32'(tx_done), 0);
        tick(1);
        chk("lock_abort_pulse", 32'(tx_abort), 0);
        channel_lock = 1'b1;
        cnt = 0;
        for (int w = 0; w < 300; w++) begin
            if (tx_done || tx_busy) cnt++;
            tick(1);
        end
        chk("lock_flushed", 32'(cnt), 0);

        // abort coinciding with the end of bit 7
        offer(8'h5A);
        wait_busy("coin");
        tick(PRE_CYC + 8 * BP - 1);
        channel_lock = 1'b0;
        tick(1);
        chk("coin_abort", 32'(tx_abort), 1);
        chk("coin_nodone", 32'(tx_done), 0);
        chk("coin_busy", 32'(tx_busy), 0);
        tick(1);
        chk("coin_nodone2", 32'(tx_done), 0);
        channel_lock = 1'b1;
        tick(2);

        // asynchronous reset during bit 5
        offer(8'hA5);
        wait_busy("rstm");
        tick(PRE_CYC + 5 * BP + 7);
        #2;
        rst = 1'b1;
        #1;
        chk("rstm_mod", 32'(data_mod), 0);
        chk("rstm_busy", 32'(tx_busy), 0);
        chk("rstm_ready", 32'(data_ready), 1);
        chk("rstm_pulses", 32'({tx_done, tx_abort}), 0);
        tick(3);
        rst = 1'b0;
        cnt = 0;
        for (int w = 0; w < 10; w++) begin
            if (tx_done || tx_abort || tx_busy) cnt++;
            tick(1);
        end
        chk("rstm_quiet", 32'(cnt), 0);
        feed_q.delete();
        feed_q.push_back(8'h01);
        push_pre();
        for (int j = 0; j < 8; j++) exp_q.push_back(j == 0);
        run_burst("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
